// File: rtl/bp_network_deserializer_if.sv
// Flit-in / message-out channel bundle for bp_network_deserializer.
// slave is the deserializer's view; master is the upstream-plus-consumer view.
interface bp_network_deserializer_if #(
    parameter int num_dest_p          = 4,
    parameter int num_src_p           = 4,
    parameter int source_data_width_p = 64,
    parameter int packet_data_width_p = 16
);
    localparam int dest_id_width_p = (num_dest_p == 1) ? 1 : $clog2(num_dest_p);
    localparam int src_id_width_p  = (num_src_p == 1) ? 1 : $clog2(num_src_p);
    localparam int flit_width_lp   = packet_data_width_p + dest_id_width_p + src_id_width_p;

    logic                           valid_i;
    logic [flit_width_lp-1:0]       data_i;
    logic                           ready_o;
    logic                           valid_o;
    logic [source_data_width_p-1:0] data_o;
    logic [dest_id_width_p-1:0]     dest_id_o;
    logic [src_id_width_p-1:0]      src_id_o;
    logic                           yumi_i;
    logic                           err_o;

    modport slave (
        input  valid_i, data_i, yumi_i,
        output ready_o, valid_o, data_o, dest_id_o, src_id_o, err_o
    );

    modport master (
        output valid_i, data_i, yumi_i,
        input  ready_o, valid_o, data_o, dest_id_o, src_id_o, err_o
    );
endinterface

// File: rtl/bp_network_deserializer.sv
// Reassembles num_packets_p flits into one message, presented on a valid/yumi channel.
// Header of flit 0 is captured; later flits with a different header raise a sticky error.
module bp_network_deserializer #(
    parameter int num_dest_p          = 4,
    parameter int num_src_p           = 4,
    parameter int source_data_width_p = 64,
    parameter int packet_data_width_p = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    bp_network_deserializer_if.slave  bus
);
    localparam int dest_id_width_p = (num_dest_p == 1) ? 1 : $clog2(num_dest_p);
    localparam int src_id_width_p  = (num_src_p == 1) ? 1 : $clog2(num_src_p);
    localparam int flit_width_lp   = packet_data_width_p + dest_id_width_p + src_id_width_p;
    localparam int num_packets_p   = (source_data_width_p + packet_data_width_p - 1) / packet_data_width_p;
    localparam int count_width_lp  = (num_packets_p == 1) ? 1 : $clog2(num_packets_p);

    typedef enum logic {COLLECT, FULL} state_t;

    state_t                         state_reg, state_next;
    logic [count_width_lp-1:0]      count_reg, count_next;
    logic [source_data_width_p-1:0] data_reg, data_next;
    logic [dest_id_width_p-1:0]     dest_reg, dest_next;
    logic [src_id_width_p-1:0]      src_reg, src_next;
    logic                           err_reg, err_next;

    logic [dest_id_width_p-1:0]     flit_dest;
    logic [src_id_width_p-1:0]      flit_src;
    logic [packet_data_width_p-1:0] flit_payload;

    assign flit_dest    = bus.data_i[flit_width_lp-1 -: dest_id_width_p];
    assign flit_src     = bus.data_i[flit_width_lp-dest_id_width_p-1 -: src_id_width_p];
    assign flit_payload = bus.data_i[packet_data_width_p-1:0];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg <= COLLECT;
            count_reg <= '0;
            data_reg  <= '0;
            dest_reg  <= '0;
            src_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            data_reg  <= data_next;
            dest_reg  <= dest_next;
            src_reg   <= src_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        data_next   = data_reg;
        dest_next   = dest_reg;
        src_next    = src_reg;
        err_next    = err_reg;
        bus.ready_o = 1'b0;
        bus.valid_o = 1'b0;
        case (state_reg)
            COLLECT: begin
                bus.ready_o = 1'b1;
                if (bus.valid_i) begin
                    // Bit-wise write keeps the last slice clipped to the message width.
                    for (int b = 0; b < source_data_width_p; b++) begin
                        if (int'(count_reg) == b / packet_data_width_p)
                            data_next[b] = flit_payload[b % packet_data_width_p];
                    end
                    if (count_reg == '0) begin
                        dest_next = flit_dest;
                        src_next  = flit_src;
                    end else if ({flit_dest, flit_src} != {dest_reg, src_reg}) begin
                        err_next = 1'b1;
                    end
                    if (count_reg == count_width_lp'(num_packets_p - 1)) begin
                        count_next = '0;
                        state_next = FULL;
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                end
            end
            FULL: begin
                bus.valid_o = 1'b1;
                if (bus.yumi_i)
                    state_next = COLLECT;
            end
            default: state_next = COLLECT;
        endcase
    end

    assign bus.data_o    = data_reg;
    assign bus.dest_id_o = dest_reg;
    assign bus.src_id_o  = src_reg;
    assign bus.err_o     = err_reg;

    // Consumer may only take a message that is actually on offer.
    a_yumi_needs_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) bus.yumi_i |-> bus.valid_o
    );
endmodule

// File: doc/bp_network_deserializer.md
Name: bp_network_deserializer

Overview:
- Receive-side counterpart of the network serializer; sits directly downstream of it across the network link.
- Accepts a stream of flits, each carrying {dest_id, src_id, packet_data}, and reassembles num_packets_p consecutive flits into one source_data_width_p-bit message.
- Presents the message on a valid/yumi output channel to the consuming engine, and flags header inconsistency within a message.

Parameters:
- num_dest_p, 4, number of destinations; dest_id_width_p = BSG_SAFE_CLOG2(num_dest_p) (localparam)
- num_src_p, 4, number of sources; src_id_width_p = BSG_SAFE_CLOG2(num_src_p) (localparam)
- source_data_width_p, 64, reassembled message width
- packet_data_width_p, 16, payload bits per flit
- num_packets_p (localparam), ceil(source_data_width_p/packet_data_width_p), flits per message
- flit_width_lp (localparam), packet_data_width_p+dest_id_width_p+src_id_width_p

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset
- valid_i  in  1  flit valid
- data_i  in  flit_width_lp  flit: [msb -: dest_id_width_p] = dest_id, next src_id_width_p bits = src_id, [0 +: packet_data_width_p] = payload
- ready_o  out  1  block can accept a flit this cycle
- valid_o  out  1  reassembled message available
- data_o  out  source_data_width_p  reassembled message
- dest_id_o  out  dest_id_width_p  dest_id of the first flit of the message
- src_id_o  out  src_id_width_p  src_id of the first flit of the message
- yumi_i  in  1  consumer takes message; legal only when valid_o=1
- err_o  out  1  sticky: header mismatch seen within a message

Behaviour:
- Reset (reset_n_i=0, asynchronous): state=COLLECT, flit count=0, valid_o=0, err_o=0, data/header registers=0. Reset takes effect immediately, including mid-message; the partial message is discarded.
- Flit accept: valid_i & ready_o, on the rising clock edge.
- State COLLECT:
  - ready_o=1, valid_o=0.
  - On accept with count k, store payload into buffer slice [k*packet_data_width_p +: packet_data_width_p]. Flit 0 fills the least-significant slice.
  - If k==0, capture dest_id and src_id into the header registers.
  - If k!=0 and the flit header != captured header, set err_o (sticky until reset). The flit is still stored and counting continues.
  - If k==num_packets_p-1, clear count and go to FULL; otherwise increment count.
- State FULL:
  - ready_o=0, valid_o=1.
  - data_o = buffer[source_data_width_p-1:0]; upper pad bits of the last slice are dropped.
  - dest_id_o and src_id_o hold the captured header.
  - On yumi_i, go to COLLECT next cycle. No flit is accepted in the yumi cycle, so minimum spacing between messages is num_packets_p+1 cycles.
- Latency: valid_o asserts the cycle after the last flit is accepted.
- data_o, dest_id_o and src_id_o are stable while valid_o=1.
- num_packets_p==1: every accepted flit completes a message; no mismatch check is possible and err_o stays 0.
- valid_i while ready_o=0: ignored and not consumed; upstream holds the flit.
- yumi_i while valid_o=0: protocol violation; assertion fires in simulation, state unchanged.
- Count width is BSG_SAFE_CLOG2(num_packets_p); count never exceeds num_packets_p-1.

Test Plan:
- Single message (defaults), no gaps: flits {dest=2,src=1} with payloads 16'h1111, 16'h2222, 16'h3333, 16'h4444 -> valid_o=1 the cycle after the 4th accept; data_o=64'h4444_3333_2222_1111; dest_id_o=2; src_id_o=1; err_o=0.
- Backpressure: hold yumi_i=0 for 5 cycles after valid_o -> ready_o=0 throughout; data_o stable; a pending valid_i flit is not taken. After yumi_i, ready_o=1 next cycle and the next message reassembles correctly.
- Gapped input: valid_i toggled 1,0,0,1,0,1,1 -> exactly 4 accepts; message identical to scenario 1.
- Header mismatch: flit 2 carries src=3 -> message still delivered with src_id_o=1; err_o=1 from the cycle after flit 2 and stays 1 across following clean messages until reset.
- Reset mid-message: assert reset_n_i low asynchronously (between clock edges) after 2 flits -> valid_o and ready_o report reset values immediately; the next 4 flits form a complete new message with no leftover data.
- Non-multiple width: source_data_width_p=40, packet_data_width_p=16 -> 3 flits; data_o = low 40 bits of the concatenated payloads; the upper 8 bits of flit 2 are dropped.
